fetch_unit: RTL and testbench

Instruction fetch stage of the single-issue MIPS datapath, directly upstream of the decode stage. It holds the program counter and a word-addressed instruction memory with one-cycle synchronous read, and buffers fetched words in a 2-entry queue so decode back-pressure never drops an instruction. It presents one instruction per cycle with its PC and PC+4. It also accepts taken-branch and jump redirects, which flush all wrong-path fetches.

---
 rtl/fetch_unit.sv | 140 ++++++++++++++
 tb/tb_fetch_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, synchronous-read instruction memory, and a 2-entry
// output queue whose head drives the decode-facing outputs directly.
module fetch_unit #(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          stall,
  input  logic                          branch_taken,
  input  logic [31:0]                   branch_offset,
  input  logic                          jump,
  input  logic [25:0]                   jump_target,
  input  logic                          load_en,
  input  logic [$clog2(IMEM_DEPTH)-1:0] load_addr,
  input  logic [31:0]                   load_data,
  output logic [31:0]                   instruction,
  output logic                          instr_valid,
  output logic [31:0]                   pc_out,
  output logic [31:0]                   pc_plus4
);

  localparam int unsigned AW = $clog2(IMEM_DEPTH);

  typedef enum logic {ST_RESET, ST_RUN} state_t;

  state_t      state, state_n;
  logic [31:0] mem [IMEM_DEPTH];
  logic [31:0] rd_data;

  logic [31:0] fetch_pc, fetch_pc_n;
  logic        inflight, inflight_n;
  logic [31:0] inflight_pc, inflight_pc_n;
  logic [1:0]  count, count_n, remain;
  logic [31:0] tail_instr, tail_instr_n, tail_pc, tail_pc_n;
  logic [31:0] instruction_n, pc_out_n, pc_plus4_n;
  logic        instr_valid_n;

  logic        consume, redirect, issue, push;
  logic [31:0] target, issue_pc;

  // Next-state: issue, redirect flush and queue update. Head entry lives in the output registers.
  always_comb begin
    state_n       = state;
    fetch_pc_n    = fetch_pc;
    count_n       = count;
    tail_instr_n  = tail_instr;
    tail_pc_n     = tail_pc;
    instruction_n = instruction;
    instr_valid_n = instr_valid;
    pc_out_n      = pc_out;
    pc_plus4_n    = pc_plus4;
    redirect      = 1'b0;

    consume = instr_valid && !stall;

    case (state)
      ST_RESET: state_n = ST_RUN;
      ST_RUN:   redirect = consume && (jump || branch_taken);
    endcase

    target = jump ? {pc_plus4[31:28], jump_target, 2'b00}
                  : pc_plus4 + (branch_offset << 2);

    issue         = redirect || ((3'(count) + 3'(inflight)) < (3'd2 + 3'(consume)));
    issue_pc      = redirect ? target : fetch_pc;
    inflight_n    = issue;
    inflight_pc_n = issue_pc;
    if (issue) fetch_pc_n = issue_pc + 32'd4;

    push   = inflight && !redirect;
    remain = count - 2'(consume);

    if (redirect) begin
      count_n       = 2'd0;
      instr_valid_n = 1'b0;
      instruction_n = 32'd0;
    end else begin
      if (consume) begin
        if (count == 2'd2) begin
          instruction_n = tail_instr;
          pc_out_n      = tail_pc;
          pc_plus4_n    = tail_pc + 32'd4;
        end else begin
          // Queue drains: instruction reads zero, PCs keep their last values.
          instruction_n = 32'd0;
          instr_valid_n = 1'b0;
        end
      end
      if (push) begin
        if (remain == 2'd0) begin
          instruction_n = rd_data;
          pc_out_n      = inflight_pc;
          pc_plus4_n    = inflight_pc + 32'd4;
          instr_valid_n = 1'b1;
        end else begin
          tail_instr_n = rd_data;
          tail_pc_n    = inflight_pc;
        end
      end
      count_n = remain + 2'(push);
    end
  end

  // State and queue registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= ST_RESET;
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= RESET_PC;
      count       <= 2'd0;
      tail_instr  <= 32'd0;
      tail_pc     <= 32'd0;
      instruction <= 32'd0;
      instr_valid <= 1'b0;
      pc_out      <= RESET_PC;
      pc_plus4    <= RESET_PC + 32'd4;
    end else begin
      state       <= state_n;
      fetch_pc    <= fetch_pc_n;
      inflight    <= inflight_n;
      inflight_pc <= inflight_pc_n;
      count       <= count_n;
      tail_instr  <= tail_instr_n;
      tail_pc     <= tail_pc_n;
      instruction <= instruction_n;
      instr_valid <= instr_valid_n;
      pc_out      <= pc_out_n;
      pc_plus4    <= pc_plus4_n;
    end
  end

  // Instruction memory: not reset; a same-index write and read returns the old word.
  always_ff @(posedge clock) begin
    if (load_en) mem[load_addr] <= load_data;
    if (issue)   rd_data <= mem[issue_pc[AW+1:2]];
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: an architectural next-PC model feeds
// an expected-instruction queue that a negedge monitor checks against the head outputs.
module tb_fetch_unit;

  localparam int unsigned DEPTH = 256;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b1;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_offset = 32'd0;
  logic        jump = 1'b0;
  logic [25:0] jump_target = 26'd0;
  logic        load_en = 1'b0;
  logic [7:0]  load_addr = 8'd0;
  logic [31:0] load_data = 32'd0;
  logic [31:0] instruction, pc_out, pc_plus4;
  logic        instr_valid;

  fetch_unit #(.IMEM_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clock(clock), .reset(reset), .stall(stall),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump(jump), .jump_target(jump_target),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .instruction(instruction), .instr_valid(instr_valid),
    .pc_out(pc_out), .pc_plus4(pc_plus4)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem_model [DEPTH];
  logic [31:0] arch_pc = RPC;
  int          errors = 0;
  int          checks = 0;

  function automatic int widx(input logic [31:0] p);
    return int'((p / 32'd4) % DEPTH);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_exp(input logic [31:0] p);
    exp_t e;
    e.pc    = p;
    e.instr = mem_model[widx(p)];
    exp_q.push_back(e);
  endtask

  // Monitor: expected valid window plus in-order comparison of the head against the scoreboard.
  int cyc = 0;
  int valid_from = 32'h3fff_ffff;
  bit prev_rst = 1'b0;

  always @(negedge clock) begin
    if (!reset) begin
      valid_from = cyc + 3;
      prev_rst   = 1'b1;
    end else begin
      if (prev_rst) begin
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instruction, 32'd0);
        check("rst_pc", pc_out, RPC);
        check("rst_pc4", pc_plus4, RPC + 32'd4);
      end
      prev_rst = 1'b0;
      check("valid", 32'(instr_valid), 32'(cyc >= valid_from));
      if (!instr_valid) begin
        check("idle_instr", instruction, 32'd0);
      end else if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got pc %h expected no instruction", pc_out);
      end else begin
        check("instr", instruction, exp_q[0].instr);
        check("pc", pc_out, exp_q[0].pc);
        check("pc4", pc_plus4, exp_q[0].pc + 32'd4);
      end
      if (instr_valid && !stall) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        if (jump || branch_taken) valid_from = cyc + 2;
      end
    end
    cyc++;
  end

  task automatic hold_reset(input logic le, input logic [7:0] la, input logic [31:0] ld);
    @(posedge clock);
    #1;
    reset        = 1'b0;
    stall        = 1'b1;
    branch_taken = 1'b0;
    jump         = 1'b0;
    load_en      = le;
    load_addr    = la;
    load_data    = ld;
    if (le) mem_model[la] = ld;
  endtask

  // One driven cycle; updates the architectural model when the head is consumed.
  task automatic step(input logic s, input logic br, input logic [31:0] off,
                      input logic jp, input logic [25:0] jt,
                      input logic le, input logic [7:0] la, input logic [31:0] ld,
                      output logic took);
    logic [31:0] nxt;
    @(posedge clock);
    #1;
    if (!reset) begin
      reset = 1'b1;
      exp_q.delete();
      arch_pc = RPC;
      push_exp(RPC);
    end
    stall         = s;
    branch_taken  = br;
    branch_offset = off;
    jump          = jp;
    jump_target   = jt;
    load_en       = le;
    load_addr     = la;
    load_data     = ld;
    took = instr_valid && !s;
    if (took) begin
      if (jp)      nxt = ((arch_pc + 32'd4) & 32'hF000_0000) | (32'(jt) * 32'd4);
      else if (br) nxt = arch_pc + 32'd4 + off * 32'd4;
      else         nxt = arch_pc + 32'd4;
      arch_pc = nxt;
      push_exp(nxt);
    end
    if (le) mem_model[la] = ld;
  endtask

  task automatic run(input int n, input logic s);
    logic took;
    for (int i = 0; i < n; i++) step(s, 1'b0, 32'd0, 1'b0, 26'd0, 1'b0, 8'd0, 32'd0, took);
  endtask

  task automatic redirect(input logic br, input logic [31:0] off, input logic jp, input logic [25:0] jt);
    logic took;
    took = 1'b0;
    for (int i = 0; i < 10 && !took; i++) step(1'b0, br, off, jp, jt, 1'b0, 8'd0, 32'd0, took);
    checks++;
    if (!took) begin
      errors++;
      $display("FAIL redirect_timeout: got no consume expected one within 10 cycles");
    end
  endtask

  initial begin
    logic took;
    for (int i = 0; i < int'(DEPTH); i++) hold_reset(1'b1, 8'(i), 32'h1000_0000 + 32'(i));
    hold_reset(1'b0, 8'd0, 32'd0);

    // Cycle 0: write word 0 while it is being read; the first instruction must be the old word.
    step(1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b1, 8'd0, 32'hDEAD_BEEF, took);
    run(8, 1'b0);
    run(3, 1'b1);
    run(4, 1'b0);
    redirect(1'b1, 32'hFFFF_FFFE, 1'b0, 26'd0);
    run(4, 1'b0);
    redirect(1'b1, 32'd5, 1'b1, 26'h40);
    run(5, 1'b0);

    for (int i = 0; i < 400; i++) begin
      logic        s, br, jp;
      logic [31:0] off;
      s   = ($urandom_range(0, 99) < 30);
      br  = ($urandom_range(0, 99) < 12);
      jp  = ($urandom_range(0, 99) < 6);
      off = ($urandom_range(0, 1) == 1) ? $urandom : ($urandom_range(0, 40) - 32'd20);
      step(s, br, off, jp, 26'($urandom), 1'b0, 8'd0, 32'd0, took);
    end

    // Word 255 followed by the wrap to word 0, then an explicit jump to 0 (new word).
    redirect(1'b0, 32'd0, 1'b1, 26'h0FF);
    run(6, 1'b0);
    redirect(1'b0, 32'd0, 1'b1, 26'h0);
    run(4, 1'b0);

    // Reset while stalled with a full queue.
    run(4, 1'b1);
    hold_reset(1'b0, 8'd0, 32'd0);
    run(8, 1'b0);
    run(2, 1'b1);
    run(4, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected end of run");
    $fatal(1, "watchdog");
  end

endmodule
